cdda_sector_streamer: RTL and testbench
=======================================

# cdda_sector_streamer

CD-DA sector producer feeding the CD audio playback FIFO. It runs on the FIFO's write-side clock and accepts play commands (start LBA, sector count) from the ATAPI/CD-ROM controller. For each sector it fetches 2352 bytes from the storage block interface as 16-bit little-endian halves and packs them into 32-bit stereo samples. It writes those samples with the FIFO's edge-detected write strobe, starting a sector only while the FIFO signals room for a whole sector.

## Interface
- SECTOR_HALVES, 1176: 16-bit halves per 2352-byte sector.
- REQ_HOLDOFF, 4: cycles `CDDA_REQ` is ignored after each sector, covering FIFO fill-count latency.

Ports:
- CLK  in  1  single clock, shared with the FIFO write side.
- RESET  in  1  synchronous, active-high reset.
- PLAY_START  in  1  pulse; latches PLAY_LBA and PLAY_COUNT when idle.
- PLAY_LBA  in  32  first sector.
- PLAY_COUNT  in  32  number of sectors.
- PLAY_STOP  in  1  pulse; abort playback.
- PAUSE  in  1  level; holds off new sectors.
- BUSY  out  1  playback active, including the drain phase.
- DONE  out  1  one-cycle pulse when the count is exhausted.
- ERROR  out  1  sticky; set by SECT_ERR, cleared by an accepted PLAY_START.
- CUR_LBA  out  32  next sector to fetch.
- REMAIN  out  32  sectors left.
- SECT_RD  out  1  sector read request; held until SECT_ACK.
- SECT_LBA  out  32  requested LBA; stable while SECT_RD is high.
- SECT_ACK  in  1  request accepted; data follows.
- SECT_DATA  in  16  sector half-word.
- SECT_VALID  in  1  SECT_DATA valid.
- SECT_READY  out  1  streamer accepts the half-word this cycle.
- SECT_ERR  in  1  storage error for the current sector.
- CDDA_REQ  in  1  FIFO has room for at least one full sector.
- CDDA_WR  out  1  write strobe; the FIFO acts on its rising edge.
- CDDA_DATA  out  32  sample: [15:0] left, [31:16] right.

## Operation
- States: IDLE, WAIT_REQ, ISSUE, RECV, DRAIN.
- IDLE:
  - PLAY_START with PLAY_COUNT≠0 → load CUR_LBA and REMAIN, clear ERROR, go to WAIT_REQ with holdoff counter = 0.
  - PLAY_START with PLAY_COUNT=0 → DONE pulse next cycle, stay IDLE.
  - PLAY_START while BUSY is ignored.
- WAIT_REQ:
  - Once the holdoff counter reaches REQ_HOLDOFF, CDDA_REQ=1 and PAUSE=0 → ISSUE.
  - PAUSE is sampled only here; a sector in progress always completes.
- ISSUE:
  - SECT_RD=1 and SECT_LBA=CUR_LBA.
  - SECT_ACK → RECV with half counter = 0.
- RECV:
  - Half-word transfer on SECT_VALID & SECT_READY.
  - Even half count → load low register; odd → CDDA_DATA <= {SECT_DATA, low}, set pending.
- pending (write cycle):
  - CDDA_WR=1 and SECT_READY=0 for exactly one cycle.
  - Next cycle: CDDA_WR=0, pending cleared.
  - CDDA_WR is never high on two consecutive cycles.
  - CDDA_DATA is held until the next odd half is accepted.
- SECT_READY = (RECV or DRAIN) & ~pending.
- End of sector:
  - Triggered when half 1175 is accepted.
  - CUR_LBA+1, REMAIN−1, both modulo 2^32.
  - REMAIN becomes 0 → DONE pulse, go to IDLE after the final write cycle; otherwise go to WAIT_REQ.
- PLAY_STOP:
  - In WAIT_REQ or ISSUE → IDLE next cycle; SECT_RD drops.
  - In RECV → DRAIN. DRAIN keeps accepting and discarding halves with no CDDA_WR, then goes to IDLE after half 1175. No DONE pulse.
  - In DRAIN or IDLE → no effect.
- SECT_ERR in ISSUE, RECV or DRAIN → set ERROR and go to IDLE. A partial word is dropped; an in-flight write cycle still completes.
- PLAY_STOP and end of sector in the same cycle → the sector completes, then IDLE with no DONE.
- RESET: all outputs 0, including CDDA_DATA, CUR_LBA and REMAIN; state IDLE; counters cleared.

## Timing
- PLAY_START at cycle t → BUSY=1 at t+1.
- Earliest SECT_RD is at t+2+REQ_HOLDOFF, given CDDA_REQ=1.
- Odd half accepted at cycle c → CDDA_WR=1 and new CDDA_DATA at c+1, CDDA_WR=0 at c+2. The next half is accepted no earlier than c+2.
- Peak rate is one 32-bit word per 3 cycles; a sector takes ≥1764 cycles after SECT_ACK.
- CDDA_REQ is sampled only in WAIT_REQ. A whole sector (588 writes) is sent per grant, which the FIFO guarantees it can absorb.
- The half counter is 11 bits; the holdoff counter saturates.

## Test plan
- Play LBA=100, COUNT=2, storage sends halves 0x0000..0x0497 with VALID always high → 1176 writes, first CDDA_DATA=0x00010000. SECT_LBA is 100 then 101. DONE pulses once; final CUR_LBA=102, REMAIN=0.
- CDDA_REQ low for 500 cycles before the second sector → no SECT_RD until REQ rises + ≥1 cycle. Verify CDDA_WR gaps ≥1 cycle and a CDDA_REQ drop mid-sector is ignored.
- PAUSE=1 during sector 1 of 3 → sector 1 completes, no SECT_RD while paused. Release → sector 2 at LBA+1.
- PLAY_STOP after 300 halves → DRAIN accepts the remaining 876 halves with zero CDDA_WR, then IDLE with BUSY=0 and no DONE.
- SECT_ERR at half 41 → ERROR=1, IDLE, 20 writes emitted. New PLAY_START clears ERROR.
- PLAY_COUNT=0 → DONE at t+1, no SECT_RD. RESET mid-RECV → all outputs 0 next cycle.

Source files
------------

// File: rtl/cdda_sector_streamer.sv
// cdda_sector_streamer: fetches CD-DA sectors from storage and packs 16-bit halves
// into 32-bit stereo samples written to the audio FIFO one sector per grant.
module cdda_sector_streamer #(
   parameter int SECTOR_HALVES = 1176,
   parameter int REQ_HOLDOFF   = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_play_start,
   input  logic [31:0] i_play_lba,
   input  logic [31:0] i_play_count,
   input  logic        i_play_stop,
   input  logic        i_pause,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [31:0] o_cur_lba,
   output logic [31:0] o_remain,
   output logic        o_sect_rd,
   output logic [31:0] o_sect_lba,
   input  logic        i_sect_ack,
   input  logic [15:0] i_sect_data,
   input  logic        i_sect_valid,
   output logic        o_sect_ready,
   input  logic        i_sect_err,
   input  logic        i_cdda_req,
   output logic        o_cdda_wr,
   output logic [31:0] o_cdda_data
);
   localparam int HW = $clog2(REQ_HOLDOFF + 1);
   typedef enum logic [2:0] {IDLE, WAIT_REQ, ISSUE, RECV, DRAIN} state_t;
   state_t r_state, w_next;
   logic [HW-1:0] r_hold;
   logic [10:0]   r_half;
   logic [15:0]   r_low;
   logic [31:0]   r_data, r_lba, r_remain;
   logic          r_pend, r_done, r_err;
   logic          w_start, w_err, w_take, w_last, w_end, w_fin;
   assign w_start      = i_play_start & (r_state == IDLE) & ~r_pend;
   assign w_err        = i_sect_err & (r_state == ISSUE || r_state == RECV || r_state == DRAIN);
   assign o_sect_ready = (r_state == RECV || r_state == DRAIN) & ~r_pend;
   assign w_take       = i_sect_valid & o_sect_ready & ~i_sect_err;
   assign w_last       = w_take & (r_half == 11'(SECTOR_HALVES - 1));
   assign w_end        = w_last & (r_state == RECV);
   assign w_fin        = w_end & (r_remain == 32'd1);
   assign o_busy       = (r_state != IDLE) | r_pend;
   assign o_done       = r_done;
   assign o_error      = r_err;
   assign o_cur_lba    = r_lba;
   assign o_remain     = r_remain;
   assign o_sect_rd    = r_state == ISSUE;
   assign o_sect_lba   = r_lba;
   assign o_cdda_wr    = r_pend;
   assign o_cdda_data  = r_data;
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_start && i_play_count != '0) w_next = WAIT_REQ;
         WAIT_REQ: if (i_play_stop) w_next = IDLE;
                   else if (r_hold == HW'(REQ_HOLDOFF) && i_cdda_req && !i_pause) w_next = ISSUE;
         ISSUE:    if (i_sect_err || i_play_stop) w_next = IDLE;
                   else if (i_sect_ack) w_next = RECV;
         RECV:     if (i_sect_err) w_next = IDLE;
                   else if (w_end) w_next = (w_fin || i_play_stop) ? IDLE : WAIT_REQ;
                   else if (i_play_stop) w_next = DRAIN;
         DRAIN:    if (i_sect_err || w_last) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hold   <= '0;
         r_half   <= '0;
         r_low    <= '0;
         r_data   <= '0;
         r_lba    <= '0;
         r_remain <= '0;
         r_pend   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= (w_start && i_play_count == '0) || (w_fin && !i_play_stop);
         r_hold <= (r_state != WAIT_REQ) ? '0 : (r_hold == HW'(REQ_HOLDOFF)) ? r_hold : r_hold + 1'b1;
         r_half <= (r_state == ISSUE) ? '0 : w_take ? (w_last ? '0 : r_half + 1'b1) : r_half;
         // a drained sector is discarded, so only RECV produces write cycles
         r_pend <= w_take & r_half[0] & (r_state == RECV);
         if (w_take && !r_half[0]) r_low <= i_sect_data;
         if (w_take && r_half[0] && r_state == RECV) r_data <= {i_sect_data, r_low};
         if (w_start && i_play_count != '0) begin
            r_lba    <= i_play_lba;
            r_remain <= i_play_count;
         end else if (w_end) begin
            r_lba    <= r_lba + 32'd1;
            r_remain <= r_remain - 32'd1;
         end
         r_err <= w_start ? 1'b0 : (w_err ? 1'b1 : r_err);
      end
   end
endmodule

// File: tb/tb_cdda_sector_streamer.sv
// tb_cdda_sector_streamer: randomized storage responder with an expected-sample
// stream and expected request-LBA list derived from the play commands.
module tb_cdda_sector_streamer;
   logic        clk = 1'b0;
   logic        i_reset, i_play_start, i_play_stop, i_pause;
   logic [31:0] i_play_lba, i_play_count;
   logic        o_busy, o_done, o_error, o_sect_rd, o_sect_ready, o_cdda_wr;
   logic [31:0] o_cur_lba, o_remain, o_sect_lba, o_cdda_data;
   logic        i_sect_ack, i_sect_valid, i_sect_err, i_cdda_req;
   logic [15:0] i_sect_data;

   cdda_sector_streamer dut (
      .i_clk(clk), .i_reset(i_reset), .i_play_start(i_play_start), .i_play_lba(i_play_lba),
      .i_play_count(i_play_count), .i_play_stop(i_play_stop), .i_pause(i_pause),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_cur_lba(o_cur_lba),
      .o_remain(o_remain), .o_sect_rd(o_sect_rd), .o_sect_lba(o_sect_lba),
      .i_sect_ack(i_sect_ack), .i_sect_data(i_sect_data), .i_sect_valid(i_sect_valid),
      .o_sect_ready(o_sect_ready), .i_sect_err(i_sect_err), .i_cdda_req(i_cdda_req),
      .o_cdda_wr(o_cdda_wr), .o_cdda_data(o_cdda_data)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          wr_cnt = 0, done_cnt = 0, halves = 0;
   int          stop_at = -1, err_at = -1;
   logic        burst = 1'b1, abort = 1'b0;
   logic [15:0] salt = '0;
   logic [31:0] first_data = '0;
   logic [31:0] exp_q[$];
   logic [31:0] lba_q[$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // storage content: a salted ramp so every sector and half is distinguishable
   function automatic logic [15:0] data_fn(input logic [31:0] lba, input int idx);
      return 16'(idx) ^ (salt * lba[15:0]);
   endfunction

   task automatic push_sector(input logic [31:0] lba, input int words);
      lba_q.push_back(lba);
      for (int w = 0; w < words; w++)
         exp_q.push_back({data_fn(lba, 2 * w + 1), data_fn(lba, 2 * w)});
   endtask

   task automatic start(input logic [31:0] lba, input logic [31:0] cnt);
      i_play_lba = lba;
      i_play_count = cnt;
      i_play_start = 1'b1;
      tick;
      i_play_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (o_busy && n < budget) begin tick; n++; end
      chk("idle_timeout", 32'(o_busy), 32'd0);
      repeat (2) tick;
   endtask

   task automatic wait_rd(input int budget, output int n);
      n = 0;
      while (!o_sect_rd && n < budget) begin tick; n++; end
      chk("rd_timeout", 32'(o_sect_rd), 32'd1);
   endtask

   task automatic wait_wr(input int target, input int budget);
      int n = 0;
      while (wr_cnt < target && n < budget) begin tick; n++; end
      chk("wr_timeout", 32'(wr_cnt >= target), 32'd1);
   endtask

   task automatic quiet_rd(input int cycles, input string name);
      logic seen = 1'b0;
      repeat (cycles) begin tick; seen |= o_sect_rd; end
      chk(name, 32'(seen), 32'd0);
   endtask

   task automatic chk_zero;
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_error", 32'(o_error), 0);
      chk("rst_cur_lba", o_cur_lba, 0);
      chk("rst_remain", o_remain, 0);
      chk("rst_sect_rd", 32'(o_sect_rd), 0);
      chk("rst_sect_lba", o_sect_lba, 0);
      chk("rst_ready", 32'(o_sect_ready), 0);
      chk("rst_wr", 32'(o_cdda_wr), 0);
      chk("rst_data", o_cdda_data, 0);
   endtask

   task automatic new_test;
      wr_cnt = 0;
      done_cnt = 0;
      exp_q.delete();
      lba_q.delete();
   endtask

   initial begin : storage
      logic [31:0] lba;
      int          idx;
      logic        acc, stopped, quit;
      i_sect_ack = 0; i_sect_valid = 0; i_sect_err = 0; i_play_stop = 0; i_sect_data = '0;
      forever begin
         tick;
         if (o_sect_rd && !abort) begin
            lba = o_sect_lba;
            repeat ($urandom_range(0, 3)) tick;
            if (o_sect_rd) begin
               i_sect_ack = 1'b1;
               tick;
               i_sect_ack = 1'b0;
               idx = 0; stopped = 0; quit = 0;
               while (idx < 1176 && !abort && !quit) begin
                  if (idx == stop_at && !stopped) begin
                     i_sect_valid = 1'b0;
                     repeat (2) tick;
                     i_play_stop = 1'b1;
                     tick;
                     i_play_stop = 1'b0;
                     stopped = 1'b1;
                  end else if (idx == err_at) begin
                     i_sect_valid = 1'b1;
                     i_sect_data = data_fn(lba, idx);
                     i_sect_err = 1'b1;
                     tick;
                     i_sect_err = 1'b0;
                     quit = 1'b1;
                  end else begin
                     i_sect_valid = burst || ($urandom_range(0, 3) != 0);
                     i_sect_data = data_fn(lba, idx);
                     acc = i_sect_valid && o_sect_ready;
                     tick;
                     if (acc) idx++;
                  end
               end
               i_sect_valid = 1'b0;
               halves = idx;
            end
         end
      end
   end

   initial begin : monitor
      logic prev_wr = 0, prev_rd = 0, prev_req = 0, prev_pause = 0, prev_done = 0;
      forever begin
         @(negedge clk);
         if (o_cdda_wr) begin
            if (wr_cnt == 0) first_data = o_cdda_data;
            wr_cnt++;
            chk("wr_gap", 32'(prev_wr), 0);
            chk("ready_in_wr", 32'(o_sect_ready), 0);
            chk("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("cdda_data", o_cdda_data, exp_q.pop_front());
         end
         if (o_sect_rd && !prev_rd) begin
            chk("rd_without_req", 32'(prev_req), 1);
            chk("rd_while_paused", 32'(prev_pause), 0);
            chk("rd_expected", 32'(lba_q.size() != 0), 1);
            if (lba_q.size() != 0) chk("sect_lba", o_sect_lba, lba_q.pop_front());
         end
         if (o_done) begin
            done_cnt++;
            chk("done_width", 32'(prev_done), 0);
         end
         prev_wr = o_cdda_wr; prev_rd = o_sect_rd; prev_done = o_done;
         prev_req = i_cdda_req; prev_pause = i_pause;
      end
   end

   initial begin : watchdog
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      i_reset = 1; i_play_start = 0; i_play_lba = '0; i_play_count = '0; i_pause = 0; i_cdda_req = 1;
      repeat (3) tick;
      chk_zero;
      i_reset = 0;
      tick;

      // two sectors, storage always valid, ramp data
      new_test; salt = 16'h0; burst = 1;
      push_sector(100, 588); push_sector(101, 588);
      start(100, 2);
      chk("busy_t1", 32'(o_busy), 1);
      wait_rd(20, n);
      chk("rd_latency", 32'(n), 32'd5);
      chk("first_sect_lba", o_sect_lba, 32'd100);
      repeat (100) tick;
      start(999, 9);
      wait_idle(10000);
      chk("a_first_data", first_data, 32'h0001_0000);
      chk("a_writes", 32'(wr_cnt), 32'd1176);
      chk("a_done", 32'(done_cnt), 32'd1);
      chk("a_cur_lba", o_cur_lba, 32'd102);
      chk("a_remain", o_remain, 32'd0);
      chk("a_leftover", 32'(exp_q.size() + lba_q.size()), 32'd0);

      // FIFO grant withheld between sectors, and dropped mid-sector
      new_test; salt = 16'h03A5; burst = 0;
      push_sector(200, 588); push_sector(201, 588);
      start(200, 2);
      wait_rd(20, n);
      repeat (200) tick;
      i_cdda_req = 0;
      wait_wr(588, 8000);
      quiet_rd(500, "b_rd_while_req_low");
      i_cdda_req = 1;
      wait_idle(10000);
      chk("b_writes", 32'(wr_cnt), 32'd1176);
      chk("b_done", 32'(done_cnt), 32'd1);
      chk("b_cur_lba", o_cur_lba, 32'd202);

      // pause holds off sectors 2..3 without cutting sector 1
      new_test; salt = 16'h0077;
      push_sector(300, 588); push_sector(301, 588); push_sector(302, 588);
      start(300, 3);
      wait_rd(20, n);
      i_pause = 1;
      wait_wr(588, 8000);
      quiet_rd(300, "c_rd_while_paused");
      i_pause = 0;
      wait_idle(20000);
      chk("c_writes", 32'(wr_cnt), 32'd1764);
      chk("c_done", 32'(done_cnt), 32'd1);
      chk("c_cur_lba", o_cur_lba, 32'd303);

      // stop after 300 halves: drain the rest silently
      new_test; salt = 16'h1234; stop_at = 300;
      push_sector(400, 150);
      start(400, 5);
      wait_idle(10000);
      stop_at = -1;
      chk("d_writes", 32'(wr_cnt), 32'd150);
      chk("d_done", 32'(done_cnt), 32'd0);
      chk("d_halves", 32'(halves), 32'd1176);

      // storage error at half 41, then restart at the LBA wrap point
      new_test; salt = 16'h0F0F; burst = 1; err_at = 41;
      push_sector(500, 20);
      start(500, 3);
      wait_idle(10000);
      err_at = -1;
      chk("e_error", 32'(o_error), 1);
      chk("e_writes", 32'(wr_cnt), 32'd20);
      chk("e_done", 32'(done_cnt), 32'd0);
      new_test; salt = 16'h5555; burst = $urandom_range(0, 1) != 0;
      push_sector(32'hFFFF_FFFF, 588);
      start(32'hFFFF_FFFF, 1);
      chk("e_error_cleared", 32'(o_error), 0);
      wait_idle(10000);
      chk("e_wrap_lba", o_cur_lba, 32'd0);
      chk("e_wrap_remain", o_remain, 32'd0);
      chk("e_wrap_done", 32'(done_cnt), 32'd1);
      chk("e_wrap_writes", 32'(wr_cnt), 32'd588);

      // zero-count play
      new_test;
      start(5, 0);
      chk("z_done", 32'(o_done), 1);
      chk("z_busy", 32'(o_busy), 0);
      tick;
      chk("z_done_clear", 32'(o_done), 0);
      quiet_rd(20, "z_no_rd");

      // reset in the middle of a sector
      new_test; salt = 16'h0009; burst = 1;
      push_sector(600, 588);
      start(600, 2);
      wait_wr(50, 4000);
      abort = 1; i_reset = 1;
      tick;
      chk_zero;
      i_reset = 0;
      exp_q.delete(); lba_q.delete();
      repeat (3) tick;
      abort = 0;
      quiet_rd(10, "r_no_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
